// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one structural full-adder cell fed LSB first, with its carry
// recirculated through a flip-flop and sum bits shifted into the result register.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  logic prop;
  logic gen;
  logic pass;

  assign prop  = a ^ b;
  assign gen   = a & b;
  assign pass  = prop & c_in;
  assign sum   = prop ^ c_in;
  assign c_out = gen | pass;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_sum;
  logic             cell_cout;

  full_adder_cell u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (cell_sum),
    .c_out (cell_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // On the last bit, 'carry' still holds the carry into the MSB, which gives signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            carry   <= c_in;
            cnt     <= '0;
            sum_out <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          sum_out <= {cell_sum, sum_out[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry   <= cell_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            c_out <= cell_cout;
            ovf   <= carry ^ cell_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
